// File: rtl/csa_pkg.sv
// csa_pkg: shared state encoding and size helpers for the carry-save accumulator
package csa_pkg;
  typedef enum logic [1:0] {ACCUM = 2'd0, RESOLVE = 2'd1, DONE = 2'd2} state_t;
  function automatic int tw(input int width, input int guard);
    return width + guard;
  endfunction
  function automatic int nchunks(input int width, input int guard, input int chunk);
    return (width + guard) / chunk;
  endfunction
endpackage

// File: rtl/csa_row.sv
// csa_row: TW-wide 3:2 compressor row; carry output is left unshifted
module csa_row #(
  parameter int TW = 8
) (
  input  logic [TW-1:0] a,
  input  logic [TW-1:0] b,
  input  logic [TW-1:0] c,
  output logic [TW-1:0] s,
  output logic [TW-1:0] co
);
  for (genvar i = 0; i < TW; i++) begin : g_bit
    fa u_fa (.a(a[i]), .b(b[i]), .ci(c[i]), .s(s[i]), .co(co[i]));
  end
endmodule

// File: rtl/fa.sv
// fa: single-bit full adder
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/rca.sv
// rca: W-bit ripple-carry adder built from fa cells
module rca #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);
  logic [W:0] cc;
  assign cc[0] = ci;
  assign co    = cc[W];
  for (genvar i = 0; i < W; i++) begin : g_bit
    fa u_fa (.a(a[i]), .b(b[i]), .ci(cc[i]), .s(s[i]), .co(cc[i+1]));
  end
endmodule

// File: rtl/csa_accumulator.sv
// csa_accumulator: carry-save operand accumulator with a chunked carry-propagate resolve pass
module csa_accumulator
  import csa_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int GUARD = 4,
  parameter int CHUNK = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [tw(WIDTH, GUARD)-1:0]   out_sum,
  output logic [GUARD:0]                out_count,
  output logic                          out_ovf
);
  localparam int TW = tw(WIDTH, GUARD);
  localparam int N  = nchunks(WIDTH, GUARD, CHUNK);
  localparam int IW = $clog2(N + 1);
  localparam int CW = GUARD + 1;

  state_t            state, state_n;
  logic [TW-1:0]     sum_r, carry_r, row_s, row_c;
  logic [CW-1:0]     count, count_n;
  logic [IW-1:0]     idx;
  logic              cy, beat, chunk_co;
  logic [CHUNK-1:0]  chunk_a, chunk_b, chunk_s;

  assign in_ready  = state == ACCUM;
  assign out_valid = state == DONE;
  assign beat      = in_valid && in_ready;
  assign count_n   = &count ? count : count + 1'b1;
  assign chunk_a   = CHUNK'(sum_r >> (idx * CHUNK));
  assign chunk_b   = CHUNK'(carry_r >> (idx * CHUNK));

  csa_row #(.TW(TW)) u_row (
    .a (sum_r),
    .b (carry_r),
    .c (TW'(in_data)),
    .s (row_s),
    .co(row_c)
  );

  rca #(.W(CHUNK)) u_rca (
    .a (chunk_a),
    .b (chunk_b),
    .ci(cy),
    .s (chunk_s),
    .co(chunk_co)
  );

  // State register; idx reaching N gives one finalize edge before DONE
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ACCUM;
    else        state <= state_n;

  // Next-state decode
  always_comb begin
    state_n = state;
    state_n = state == ACCUM   ? (beat && in_last ? RESOLVE : ACCUM) :
              state == RESOLVE ? (idx == IW'(N) ? DONE : RESOLVE) :
              state == DONE    ? (out_ready ? ACCUM : DONE) : ACCUM;
  end

  // Datapath: compress on beats, resolve one chunk per cycle, clear on handshake
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sum_r     <= '0;
      carry_r   <= '0;
      count     <= '0;
      idx       <= '0;
      cy        <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (state == ACCUM && beat) begin
      sum_r   <= row_s;
      carry_r <= TW'({row_c, 1'b0});
      count   <= count_n;
      if (in_last) begin
        idx       <= '0;
        cy        <= 1'b0;
        out_count <= count_n;
        out_ovf   <= count_n > (CW'(1) << GUARD);
      end
    end else if (state == RESOLVE && idx != IW'(N)) begin
      for (int k = 0; k < N; k++)
        if (idx == IW'(k)) out_sum[k*CHUNK +: CHUNK] <= chunk_s;
      cy  <= chunk_co;
      idx <= idx + 1'b1;
    end else if (state == DONE && out_ready) begin
      sum_r   <= '0;
      carry_r <= '0;
      count   <= '0;
      cy      <= 1'b0;
    end
endmodule

// File: doc/csa_accumulator.md
# csa_accumulator

Streaming multi-operand accumulator that consumes WIDTH-bit operands one per handshake beat. It compresses each operand into a redundant carry-save pair (sum, carry) using a 3:2 full-adder row, then resolves the pair back to a binary total with a multi-cycle chunked carry-propagate pass. It is the consumer of the carry-save representation. Upstream producers stream operands in; downstream logic receives one resolved binary total per packet.

## Interface
- WIDTH, 4: operand width in bits.
- GUARD, 4: extra accumulator bits; 2^GUARD operands per packet are guaranteed not to wrap.
- CHUNK, 4: bits resolved per cycle in the carry-propagate pass; must divide TW = WIDTH+GUARD.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  WIDTH  unsigned operand.
- in_last  in  1  marks the final beat of a packet.
- out_valid  out  1  resolved total available.
- out_ready  in  1  downstream accepts the total.
- out_sum  out  TW  binary total, modulo 2^TW.
- out_count  out  GUARD+1  number of beats in the packet, saturating at all-ones.
- out_ovf  out  1  out_count > 2^GUARD, so the total may have wrapped.

## Operation
- States: ACCUM, RESOLVE, DONE. Reset state is ACCUM.
- Reset values: sum_r=0, carry_r=0, count=0, in_ready=1, out_valid=0, out_sum=0, out_count=0, out_ovf=0.
- ACCUM behaviour:
  - in_ready=1.
  - A beat is accepted when in_valid && in_ready.
  - On a beat: sum_r <= s ^ c ^ x and carry_r <= majority(s,c,x) << 1, where x is in_data zero-extended to TW. The carry's top bit is dropped (modulo 2^TW).
  - On a beat: count <= count+1, saturating.
  - A beat with in_last moves to RESOLVE, after the same compression update.
  - With no beat, all state holds.
- RESOLVE behaviour:
  - in_ready=0.
  - Runs N = TW/CHUNK cycles.
  - In cycle i (i=0..N-1), chunk i of sum_r + carry_r + cy is added. Chunk result goes to out_sum[i*CHUNK +: CHUNK]; the chunk carry goes into the cy register (cy=0 at entry).
  - The final carry-out is discarded.
  - After the N-th edge, move to DONE.
  - out_count and out_ovf are registered at RESOLVE entry.
- DONE behaviour:
  - out_valid=1; out_sum, out_count and out_ovf are stable until the handshake.
  - On out_valid && out_ready: move to ACCUM, clear sum_r, carry_r, count and cy, and drop out_valid.
  - out_sum keeps its last value (not cleared) until the next packet overwrites it.
- Mid-operation reset: asynchronous clear to the reset values from any state. A partial packet is discarded.
- out_ready is ignored outside DONE. in_valid is ignored outside ACCUM.

## Timing
- Beat acceptance: one operand per cycle in ACCUM, zero bubbles.
- Latency: out_valid rises N+1 rising edges after the edge that accepts the last beat. With defaults (TW=8, N=2) that is 3 edges.
- in_ready is 0 from the edge after the last beat until the edge after the output handshake. Minimum 1 cycle between packets on top of the latency.
- No combinational path from in_valid to in_ready or from out_ready to out_valid. in_ready and out_valid are decoded from registered state.
- Critical path: one full-adder row (ACCUM) or one CHUNK-bit ripple (RESOLVE).

## Structure
- Shared package csa_pkg holds:
  - state encoding constants ACCUM=2'd0, RESOLVE=2'd1, DONE=2'd2;
  - helper function for TW;
  - helper function for N=TW/CHUNK.
- Natural sub-module csa_row: parameterised TW-wide 3:2 compressor row of fa cells, combinational, outputs (s, c unshifted).
- The chunked resolver reuses the existing rca as a CHUNK-wide instance.

## Test plan
- Beats 15,15,15,15(last) -> out_sum=60, out_count=4, out_ovf=0; out_valid high exactly 3 edges after the last accept.
- Single beat 9 with in_last -> out_sum=9, out_count=1, out_ovf=0.
- 17 beats of 15 -> out_sum=255, out_count=17, out_ovf=1.
- 18 beats of 15 -> out_sum=14 (270 mod 256), out_ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> out_sum/out_count stable, in_ready=0, no beat accepted. Release -> ACCUM on the next edge.
- Assert rst_n=0 during RESOLVE -> all outputs at reset values immediately. Next packet 3,4(last) -> out_sum=7, out_count=2.
- Back-to-back packets with out_ready tied high and in_valid gaps -> each total correct, no state leak between packets.
